// File: rtl/morse_key_sequencer.sv
// Morse key timing sequencer: walks an external dot/dash tree, commits letters.
// Optional MORSE_KEY_SYNC_EN adds a two-flop synchronizer on key.
module morse_key_sequencer #(
  parameter int DASH_UNITS = 2,
  parameter int LETTER_GAP = 3,
  parameter int WORD_GAP   = 7,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key,
  output logic [5:0] cur_state,
  input  logic [5:0] dot_next,
  input  logic [5:0] dash_next,
  output logic [5:0] letter_code,
  output logic       letter_err,
  output logic       letter_valid,
  input  logic       letter_ready,
  output logic       word_valid,
  output logic       overflow,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    WORDWAIT
  } state_t;

  localparam logic [CNT_W-1:0] DASH_C = CNT_W'(DASH_UNITS);
  localparam logic [CNT_W-1:0] LGAP_C = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WGAP_C = CNT_W'(WORD_GAP);
  localparam logic [5:0]       ERR_C  = 6'b101000;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [5:0]       cur_q, cur_d;
  logic             commit, word_d;
  logic             key_i;

`ifdef MORSE_KEY_SYNC_EN
  logic key_s1, key_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  assign key_i = key_s2;
`else
  assign key_i = key;
`endif

  // saturating increment
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    commit  = 1'b0;
    word_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        cur_d = '0;
        if (key_i) state_d = PRESS;
      end
      PRESS: begin
        // release wins over a coincident tick
        if (!key_i) begin
          cur_d   = (cnt_q < DASH_C) ? dot_next : dash_next;
          cnt_d   = '0;
          state_d = GAP;
        end else if (tick) begin
          cnt_d = cnt_inc;
        end
      end
      GAP: begin
        if (key_i) begin
          cnt_d   = '0;
          state_d = PRESS;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc == LGAP_C) begin
            commit  = 1'b1;
            cur_d   = '0;
            state_d = WORDWAIT;
          end
        end
      end
      WORDWAIT: begin
        if (key_i) begin
          cnt_d   = '0;
          state_d = PRESS;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= WGAP_C) begin
            word_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      letter_code  <= '0;
      letter_err   <= 1'b0;
      letter_valid <= 1'b0;
      word_valid   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      word_valid <= word_d;
      if (commit && (!letter_valid || letter_ready)) begin
        letter_code  <= cur_q;
        letter_err   <= (cur_q == ERR_C);
        letter_valid <= 1'b1;
      end else if (commit) begin
        overflow <= 1'b1;
      end else if (letter_valid && letter_ready) begin
        letter_valid <= 1'b0;
      end
    end
  end

  assign cur_state = cur_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer: heap-style tree (dot=2c+1, dash=2c+2).
// Default build timing (key used directly).
module tb_morse_key_sequencer;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       key;
  logic [5:0] cur_state;
  logic [5:0] dot_next;
  logic [5:0] dash_next;
  logic [5:0] letter_code;
  logic       letter_err;
  logic       letter_valid;
  logic       letter_ready;
  logic       word_valid;
  logic       overflow;
  logic       busy;
  logic       force_err;

  int n_chk;
  int n_fail;

  morse_key_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .key          (key),
    .cur_state    (cur_state),
    .dot_next     (dot_next),
    .dash_next    (dash_next),
    .letter_code  (letter_code),
    .letter_err   (letter_err),
    .letter_valid (letter_valid),
    .letter_ready (letter_ready),
    .word_valid   (word_valid),
    .overflow     (overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    dot_next  = 6'd0;
    dash_next = 6'd0;
    if (force_err) begin
      dot_next = 6'b101000;
    end else if (cur_state >= 6'd32) begin
      dot_next = cur_state;
    end else begin
      dot_next = 6'(cur_state * 2 + 1);
    end
    if (cur_state >= 6'd32) begin
      dash_next = cur_state;
    end else begin
      dash_next = 6'(cur_state * 2 + 2);
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic k);
    tick = t;
    key  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic cycn(input int n, input logic t, input logic k);
    for (int i = 0; i < n; i++) cyc(t, k);
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    tick         = 1'b0;
    key          = 1'b0;
    letter_ready = 1'b0;
    force_err    = 1'b0;
    #3;
    chk("rst_valid", 8'(letter_valid), 8'h0);
    chk("rst_cur", 8'(cur_state), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_ovf", 8'(overflow), 8'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single dot, letter gap
    cyc(0, 1);
    chk("a_busy", 8'(busy), 8'h1);
    cyc(1, 1);
    cyc(0, 0);
    chk("a_cur_dot", 8'(cur_state), 8'h01);
    cycn(2, 1, 0);
    chk("a_no_commit", 8'(letter_valid), 8'h0);
    cyc(1, 0);
    chk("a_valid", 8'(letter_valid), 8'h1);
    chk("a_code", 8'(letter_code), 8'h01);
    chk("a_err", 8'(letter_err), 8'h0);
    chk("a_cur_root", 8'(cur_state), 8'h00);
    letter_ready = 1'b1;
    cyc(0, 0);
    chk("a_drop", 8'(letter_valid), 8'h0);
    cycn(3, 1, 0);
    chk("a_word_early", 8'(word_valid), 8'h0);
    cyc(1, 0);
    chk("a_word", 8'(word_valid), 8'h1);
    chk("a_idle", 8'(busy), 8'h0);
    cyc(0, 0);
    chk("a_word_pulse", 8'(word_valid), 8'h0);

    // dash, dash, full word gap with ready held
    cyc(0, 1);
    cycn(4, 1, 1);
    cyc(0, 0);
    chk("b_cur_dash1", 8'(cur_state), 8'h02);
    cyc(1, 0);
    cyc(0, 1);
    chk("b_cur_kept", 8'(cur_state), 8'h02);
    cycn(4, 1, 1);
    cyc(0, 0);
    chk("b_cur_dash2", 8'(cur_state), 8'h06);
    cycn(3, 1, 0);
    chk("b_valid", 8'(letter_valid), 8'h1);
    chk("b_code", 8'(letter_code), 8'h06);
    cyc(1, 0);
    chk("b_drop", 8'(letter_valid), 8'h0);
    cycn(2, 1, 0);
    chk("b_word_early", 8'(word_valid), 8'h0);
    chk("b_busy", 8'(busy), 8'h1);
    cyc(1, 0);
    chk("b_word", 8'(word_valid), 8'h1);
    cyc(0, 0);
    chk("b_word_pulse", 8'(word_valid), 8'h0);
    chk("b_idle", 8'(busy), 8'h0);

    // zero-tick dot into the invalid sink
    force_err = 1'b1;
    cyc(0, 1);
    cyc(0, 0);
    force_err = 1'b0;
    chk("c_cur_sink", 8'(cur_state), 8'h28);
    cycn(3, 1, 0);
    chk("c_code", 8'(letter_code), 8'h28);
    chk("c_err", 8'(letter_err), 8'h1);
    cycn(4, 1, 0);
    chk("c_idle", 8'(busy), 8'h0);

    // two letters without ready
    letter_ready = 1'b0;
    cyc(0, 1);
    cyc(0, 0);
    cycn(3, 1, 0);
    chk("d_code1", 8'(letter_code), 8'h01);
    chk("d_err1", 8'(letter_err), 8'h0);
    cyc(0, 1);
    cycn(2, 1, 1);
    cyc(0, 0);
    chk("d_dash_at_2", 8'(cur_state), 8'h02);
    cycn(3, 1, 0);
    chk("d_ovf", 8'(overflow), 8'h1);
    chk("d_held", 8'(letter_code), 8'h01);
    chk("d_still_valid", 8'(letter_valid), 8'h1);
    letter_ready = 1'b1;
    cyc(0, 0);
    chk("d_drop", 8'(letter_valid), 8'h0);
    chk("d_ovf_sticky", 8'(overflow), 8'h1);
    letter_ready = 1'b0;
    cycn(4, 1, 0);
    chk("d_idle", 8'(busy), 8'h0);

    // release coincident with tick at cnt=1, then async reset mid-gap
    cyc(0, 1);
    cyc(1, 1);
    cyc(1, 0);
    chk("e_coincident_dot", 8'(cur_state), 8'h01);
    cyc(1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_rst_cur", 8'(cur_state), 8'h0);
    chk("e_rst_busy", 8'(busy), 8'h0);
    chk("e_rst_ovf", 8'(overflow), 8'h0);
    chk("e_rst_valid", 8'(letter_valid), 8'h0);
    chk("e_rst_word", 8'(word_valid), 8'h0);
    chk("e_rst_code", 8'(letter_code), 8'h0);
    #2;
    rst_n = 1'b1;
    cyc(0, 1);
    cyc(0, 0);
    chk("e_root_restart", 8'(cur_state), 8'h01);
    cycn(3, 1, 0);
    chk("e_valid", 8'(letter_valid), 8'h1);
    chk("e_code", 8'(letter_code), 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_key_sequencer.md
MORSE_KEY_SEQUENCER -- requirements
Module: morse_key_sequencer

Interface
REQ-001 Parameter DASH_UNITS, default 2: press length in ticks at or above which a press is a dash.
REQ-002 Parameter LETTER_GAP, default 3: release length in ticks that ends a letter.
REQ-003 Parameter WORD_GAP, default 7: release length in ticks that ends a word; SHALL exceed LETTER_GAP.
REQ-004 Parameter CNT_W, default 4: timing counter width; 2^CNT_W-1 SHALL exceed WORD_GAP.
REQ-005 clk  in  1  single clock; every register SHALL use its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 tick  in  1  one-cycle time-unit strobe.
REQ-008 key  in  1  debounced key level; 1 = pressed.
REQ-009 cur_state  out  6  current decode-tree code, driven to the external dot/dash next-state tables.
REQ-010 dot_next  in  6  dot-table result for cur_state.
REQ-011 dash_next  in  6  dash-table result for cur_state.
REQ-012 letter_code  out  6  committed tree code.
REQ-013 letter_err  out  1  committed code equals 6'b101000, the invalid sink.
REQ-014 letter_valid  out  1  letter available.
REQ-015 letter_ready  in  1  consumer accepts the letter.
REQ-016 word_valid  out  1  one-cycle end-of-word pulse.
REQ-017 overflow  out  1  sticky flag: a letter was dropped.
REQ-018 busy  out  1  FSM state is not IDLE.

Function
REQ-019 FSM states: IDLE, PRESS, GAP, WORDWAIT. One timing counter cnt, CNT_W bits, saturating at all ones.
REQ-020 IDLE: cur_state = 0, cnt held at 0. key=1 -> PRESS with cnt=0.
REQ-021 PRESS: tick increments cnt. When key=0: cnt<DASH_UNITS loads cur_state<=dot_next, otherwise cur_state<=dash_next. Next state is GAP with cnt=0.
REQ-022 If key falls in the same cycle as tick, the release takes priority and that tick is not counted. A zero-tick press is a dot.
REQ-023 GAP: key=1 -> PRESS with cnt=0, cur_state kept. Otherwise tick increments cnt. When the incremented value equals LETTER_GAP, a commit occurs: cur_state<=0, next state is WORDWAIT, cnt keeps counting.
REQ-024 WORDWAIT: key=1 -> PRESS with cnt=0. Otherwise tick increments cnt. When cnt reaches WORD_GAP, word_valid pulses for exactly one cycle and the FSM goes to IDLE.
REQ-025 Commit with the output register empty, or with letter_valid&&letter_ready in that cycle: letter_code<=cur_state, letter_err<=(cur_state==6'b101000), letter_valid<=1. Latency is one clock after the qualifying tick.
REQ-026 Commit while letter_valid=1 and letter_ready=0: the new letter is dropped, the held letter is unchanged, and overflow<=1.
REQ-027 letter_valid SHALL stay high with letter_code and letter_err stable until a cycle with letter_ready=1. It clears on the next edge unless a commit reloads it in the same cycle.
REQ-028 letter_ready while letter_valid=0 has no effect.
REQ-029 Codes >= 32 (leaves) feed back through the tables unchanged. The sequencer applies no symbol-count limit.
REQ-030 busy = (state != IDLE), combinational from state.

Reset
REQ-031 rst_n=0 SHALL immediately force:
- state to IDLE and cnt to 0;
- cur_state to 0;
- letter_code to 0, letter_err to 0, letter_valid to 0;
- word_valid to 0, overflow to 0.
REQ-032 Reset in mid-letter or mid-handshake discards all pending data. After release, the first key press starts from tree root 0.
REQ-033 overflow SHALL clear only on reset.

Configuration
REQ-034 Macro MORSE_KEY_SYNC_EN.
- Defined: key passes through a two-flop synchronizer, reset to 0, before FSM use. All key-driven transitions are delayed by 2 cycles.
- Undefined: key is used directly.
- All other behaviour is identical in both builds.

Verification
REQ-035 Press 1 tick, release 3 ticks -> one letter_valid, letter_code=6'b000001, letter_err=0.
REQ-036 Press 4 ticks, release 1 tick, press 4 ticks, release 7 ticks, ready=1 -> cur_state sequence follows dash_next twice; one letter commit; word_valid pulse exactly 1 cycle later at cnt=7; busy low afterward.
REQ-037 Drive dot_next=6'b101000 for one dot, then a letter gap -> letter_code=6'b101000, letter_err=1.
REQ-038 Two letters committed with letter_ready=0 -> first letter held, overflow=1. Then ready=1 -> letter_valid drops after one cycle.
REQ-039 Key release coincident with tick at cnt=1 -> dot selected. rst_n pulse mid-GAP -> all outputs 0 with no clock edge.
REQ-040 Build with MORSE_KEY_SYNC_EN -> REQ-035 passes with PRESS entry 2 cycles later than in the plain build.
